// File: rtl/reset_sequencer.sv
// reset_sequencer: debounces the PLL lock flag and releases staged resets,
// peripherals first and then the CPU core. Any loss of lock re-asserts all
// resets and restarts the sequence.
// Optional feature macro RESET_SEQ_LOSS_COUNT_EN adds an 8-bit saturating
// lock_loss_count output.
module reset_sequencer #(
   parameter int SYNC_STAGES      = 2,    // 2..4
   parameter int LOCK_HOLD_CYCLES = 1024, // >= 1
   parameter int CPU_DELAY_CYCLES = 16    // >= 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       locked,
   output logic       periph_reset,
   output logic       cpu_reset,
   output logic       ready,
   output logic [1:0] state
`ifdef RESET_SEQ_LOSS_COUNT_EN
   ,
   output logic [7:0] lock_loss_count
`endif
);

   localparam int MAX_CYC = (LOCK_HOLD_CYCLES > CPU_DELAY_CYCLES) ?
                            LOCK_HOLD_CYCLES : CPU_DELAY_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LOCK_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(CPU_DELAY_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      PERIPH    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     locked_sync;
   logic                     periph_rst_q, periph_rst_d;
   logic                     cpu_rst_q, cpu_rst_d;
   logic                     ready_q, ready_d;

   assign locked_sync = sync_q[SYNC_STAGES-1];

   // Shift the asynchronous lock flag through the synchronizer chain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
   end

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      unique case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_sync) state_d = HOLD;
         end
         HOLD: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = PERIPH;
               cnt_d   = '0;
            end
         end
         PERIPH: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == DELAY_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            // counter is idle here; hold it at zero
            cnt_d = '0;
            if (!locked_sync) state_d = WAIT_LOCK;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
      // Outputs are a pure function of the next state so they change on the
      // same edge as the state and come straight from flops.
      periph_rst_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
      cpu_rst_d    = (state_d != RUN);
      ready_d      = (state_d == RUN);
   end

   // State, counter and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= WAIT_LOCK;
         cnt_q        <= '0;
         periph_rst_q <= 1'b1;
         cpu_rst_q    <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         periph_rst_q <= periph_rst_d;
         cpu_rst_q    <= cpu_rst_d;
         ready_q      <= ready_d;
      end
   end

   assign periph_reset = periph_rst_q;
   assign cpu_reset    = cpu_rst_q;
   assign ready        = ready_q;
   assign state        = state_q;

`ifdef RESET_SEQ_LOSS_COUNT_EN
   logic [7:0] loss_q, loss_d;
   logic       loss_evt;

   // A lock drop out of any non-idle state is one loss event
   assign loss_evt = (state_q != WAIT_LOCK) && !locked_sync;

   // Saturating increment of the loss counter
   always_comb begin
      loss_d = loss_q;
      if (loss_evt && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
   end

   // Loss counter register, cleared only by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) loss_q <= 8'd0;
      else       loss_q <= loss_d;
   end

   assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with default parameters:
// table-driven vectors for the clean-lock / lock-loss timeline plus
// hand-written sequences for glitch, PERIPH loss and async reset.
module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       locked;
   logic       periph_reset, cpu_reset, ready;
   logic [1:0] state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
   logic [7:0] lock_loss_count;
`endif

   int n_pass = 0;
   int n_total = 0;
   int inv_viol = 0;

   reset_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .locked       (locked),
      .periph_reset (periph_reset),
      .cpu_reset    (cpu_reset),
      .ready        (ready),
      .state        (state)
`ifdef RESET_SEQ_LOSS_COUNT_EN
      ,
      .lock_loss_count (lock_loss_count)
`endif
   );

   always #10 clock = ~clock;

   // {periph_reset, cpu_reset, ready, state}
   typedef struct {
      string      name;
      logic       rst;
      logic       lck;
      int         cycles;
      logic [4:0] exp;
   } vec_t;

   localparam logic [4:0] O_WAIT   = 5'b110_00;
   localparam logic [4:0] O_HOLD   = 5'b110_01;
   localparam logic [4:0] O_PERIPH = 5'b010_10;
   localparam logic [4:0] O_RUN    = 5'b001_11;

   // Ordering invariant: cpu_reset low with periph_reset high is illegal
   always @(negedge clock) begin
      if (reset === 1'b0 && cpu_reset === 1'b0 && periph_reset === 1'b1)
         inv_viol++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [7:0] outs();
      return {3'b000, periph_reset, cpu_reset, ready, state};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      locked = 1'b0;
      step(3);
      reset = 1'b0;
      step(1);
   endtask

   vec_t vecs[12];

   initial begin
      reset  = 1'b1;
      locked = 1'b0;
      // k = first edge sampling locked=1; each row's cycle count lands
      // cumulatively on the annotated edge.
      vecs[0]  = '{"por",          1'b1, 1'b0,    5, O_WAIT};
      vecs[1]  = '{"post_rst",     1'b0, 1'b0,    3, O_WAIT};
      vecs[2]  = '{"k+1",          1'b0, 1'b1,    2, O_WAIT};
      vecs[3]  = '{"k+2_hold",     1'b0, 1'b1,    1, O_HOLD};
      vecs[4]  = '{"k+1025",       1'b0, 1'b1, 1023, O_HOLD};
      vecs[5]  = '{"k+1026_periph",1'b0, 1'b1,    1, O_PERIPH};
      vecs[6]  = '{"k+1041",       1'b0, 1'b1,   15, O_PERIPH};
      vecs[7]  = '{"k+1042_run",   1'b0, 1'b1,    1, O_RUN};
      vecs[8]  = '{"run_stable",   1'b0, 1'b1,   20, O_RUN};
      vecs[9]  = '{"loss_j+1",     1'b0, 1'b0,    2, O_RUN};
      vecs[10] = '{"loss_j+2",     1'b0, 1'b0,    1, O_WAIT};
      vecs[11] = '{"relock_hold",  1'b0, 1'b1,    3, O_HOLD};

      #1;
      chk("reset_async_initial", outs(), {3'b000, O_WAIT});

      for (int i = 0; i < 12; i++) begin
         reset  = vecs[i].rst;
         locked = vecs[i].lck;
         step(vecs[i].cycles);
         chk(vecs[i].name, outs(), {3'b000, vecs[i].exp});
      end

      // Glitch: 500 high, 3 low, then high again; HOLD restarts from zero
      do_reset();
      locked = 1'b1;
      step(500);                     // k+499
      chk("glitch_hold", outs(), {3'b000, O_HOLD});
      locked = 1'b0;
      step(3);                       // k+502
      chk("glitch_wait", outs(), {3'b000, O_WAIT});
      locked = 1'b1;
      step(524);                     // k+1026, original release point
      chk("glitch_no_release", outs(), {3'b000, O_HOLD});
      step(502);                     // k+1528
      chk("glitch_k+1528", outs(), {3'b000, O_HOLD});
      step(1);                       // k+1529 = re-entry(k+505) + 1024
      chk("glitch_release", outs(), {3'b000, O_PERIPH});
      step(16);
      chk("glitch_run", outs(), {3'b000, O_RUN});

      // Async reset mid-cycle from RUN: no clock edge needed
      #5;
      reset = 1'b1;
      #1;
      chk("async_rst_midcycle", outs(), {3'b000, O_WAIT});
      step(2);
      chk("async_rst_held", outs(), {3'b000, O_WAIT});
      reset = 1'b0;

      // Lock loss in PERIPH, 5 cycles after periph_reset falls
      step(1);
      locked = 1'b1;
      step(1027);                    // k+1026
      chk("pl_periph", outs(), {3'b000, O_PERIPH});
      step(5);
      locked = 1'b0;
      step(2);                       // j+1
      chk("pl_j+1", outs(), {3'b000, O_PERIPH});
      step(1);                       // j+2
      chk("pl_j+2_wait", outs(), {3'b000, O_WAIT});
      locked = 1'b1;
      step(40);
      chk("pl_relock_hold", outs(), {3'b000, O_HOLD});

`ifdef RESET_SEQ_LOSS_COUNT_EN
      do_reset();
      chk("llc_reset", lock_loss_count, 8'd0);
      for (int i = 0; i < 300; i++) begin
         locked = 1'b1;
         step(3);                    // HOLD entered
         locked = 1'b0;
         step(3);                    // back in WAIT_LOCK
         if (i == 0) chk("llc_first", lock_loss_count, 8'd1);
         if (i == 99) chk("llc_100", lock_loss_count, 8'd100);
      end
      chk("llc_sat", lock_loss_count, 8'd255);
      #3;
      reset = 1'b1;
      #1;
      chk("llc_async_clr", lock_loss_count, 8'd0);
      step(1);
      reset = 1'b0;
`endif

      chk("order_invariant", inv_viol[7:0], 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
